// File: rtl/ips2l_seu_uart_pkg.sv
// ips2l_seu_uart_pkg
// Shared definitions for the SEU UART receive path: FSM state encodings,
// frame geometry, default tick parameters, framing-bit index constants and
// small helpers that classify a frame bit index.
package ips2l_seu_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } rx_state_e;

    localparam int FRAME_BITS          = 38;
    localparam int DEFAULT_BIT_TICKS   = 6;
    localparam int DEFAULT_SAMPLE_TICK = 2;

    // Framing bits inside the 38-bit payload: a mark (1) follows each byte,
    // then a space (0) precedes the next byte.
    localparam logic [5:0] IDX_MARK_0  = 6'd8;
    localparam logic [5:0] IDX_SPACE_0 = 6'd9;
    localparam logic [5:0] IDX_MARK_1  = 6'd18;
    localparam logic [5:0] IDX_SPACE_1 = 6'd19;
    localparam logic [5:0] IDX_MARK_2  = 6'd28;
    localparam logic [5:0] IDX_SPACE_2 = 6'd29;
    localparam logic [5:0] IDX_LAST    = 6'd37;

    function automatic logic is_mark_idx(input logic [5:0] idx);
        return (idx == IDX_MARK_0) || (idx == IDX_MARK_1) || (idx == IDX_MARK_2);
    endfunction

    function automatic logic is_space_idx(input logic [5:0] idx);
        return (idx == IDX_SPACE_0) || (idx == IDX_SPACE_1) || (idx == IDX_SPACE_2);
    endfunction

    function automatic logic is_data_idx(input logic [5:0] idx);
        return !is_mark_idx(idx) && !is_space_idx(idx);
    endfunction

    // Position of a payload data bit inside the assembled 32-bit word;
    // every byte boundary skips the two framing bits.
    function automatic logic [4:0] data_pos(input logic [5:0] idx);
        logic [5:0] pos;
        if (idx < 6'd8) begin
            pos = idx;
        end else if (idx < 6'd18) begin
            pos = idx - 6'd2;
        end else if (idx < 6'd28) begin
            pos = idx - 6'd4;
        end else begin
            pos = idx - 6'd6;
        end
        return pos[4:0];
    endfunction

endpackage

// File: rtl/ips2l_seu_sync_2ff.sv
// ips2l_seu_sync_2ff
// Two-flop synchronizer for an asynchronous level input. Both flops reset
// to 1 so an idle-high serial line does not look like a start edge when
// reset is released.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   i_d   : asynchronous input
//   o_q   : synchronized output (2 clk latency)
module ips2l_seu_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ips2l_seu_uart_rx.sv
// ips2l_seu_uart_rx
// Receiver for a 40-bit serial frame: start(0), 38 payload bits LSB first
// (four data bytes separated by 1/0 framing pairs), stop(1). Bits are timed
// by BIT_TICKS clk_en pulses and sampled at sub-tick SAMPLE_TICK.
//   clk           : single clock
//   rst_n         : asynchronous active-low reset
//   clk_en        : one-cycle baud-tick enable
//   rxd           : serial line, idles high, asynchronous to clk
//   rx_data       : last correctly received 32-bit word
//   rx_data_valid : one-cycle pulse, rx_data updated
//   rx_frame_err  : one-cycle pulse, current frame aborted
//   rx_busy       : high while the FSM is not IDLE
module ips2l_seu_uart_rx
    import ips2l_seu_uart_pkg::*;
#(
    parameter int BIT_TICKS   = DEFAULT_BIT_TICKS,
    parameter int SAMPLE_TICK = DEFAULT_SAMPLE_TICK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        rxd,
    output logic [31:0] rx_data,
    output logic        rx_data_valid,
    output logic        rx_frame_err,
    output logic        rx_busy
);

    localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [TW-1:0] TICK_SMP  = TW'(SAMPLE_TICK);

    rx_state_e   r_state;
    rx_state_e   w_state_nxt;
    logic [TW-1:0] r_tick;
    logic [5:0]  r_idx;
    logic [31:0] r_shift;
    logic [31:0] r_data;
    logic        r_valid;
    logic        r_err;
    logic        r_busy;
    logic        r_rxd_prev;

    logic        w_rxd_sync;
    logic        w_fall;
    logic        w_sample;
    logic        w_advance;
    logic        w_frame_bad;
    logic        w_valid_nxt;
    logic        w_err_nxt;

    ips2l_seu_sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rxd),
        .o_q   (w_rxd_sync)
    );

    assign w_fall      = r_rxd_prev & ~w_rxd_sync;
    assign w_sample    = clk_en & (r_tick == TICK_SMP);
    assign w_advance   = clk_en & (r_tick == TICK_LAST);
    assign w_frame_bad = (is_mark_idx(r_idx) & ~w_rxd_sync) |
                         (is_space_idx(r_idx) & w_rxd_sync);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; stop and error decisions are taken at the sample
    // point so a back-to-back start bit is already seen from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_sample && w_rxd_sync) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_advance) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (w_sample && w_frame_bad) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_advance && (r_idx == IDX_LAST)) begin
                    w_state_nxt = ST_STOP;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_STOP: begin
                if (w_sample) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode: pulses for the next clk; valid and error are mutually
    // exclusive because they depend on opposite values of the same sample.
    always_comb begin
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_DATA: begin
                if (w_sample && w_frame_bad) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_err_nxt = 1'b0;
                end
            end
            ST_STOP: begin
                if (w_sample) begin
                    w_valid_nxt = w_rxd_sync;
                    w_err_nxt   = ~w_rxd_sync;
                end else begin
                    w_valid_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_err_nxt   = 1'b0;
            end
        endcase
    end

    // Datapath: edge history, sub-tick counter, bit index, word assembly
    // and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxd_prev <= 1'b1;
            r_tick     <= {TW{1'b0}};
            r_idx      <= 6'd0;
            r_shift    <= 32'd0;
            r_data     <= 32'd0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rxd_prev <= w_rxd_sync;

            if (r_state == ST_IDLE) begin
                if (w_fall) begin
                    r_tick <= {TW{1'b0}};
                end
            end else if (clk_en) begin
                if (r_tick == TICK_LAST) begin
                    r_tick <= {TW{1'b0}};
                end else begin
                    r_tick <= r_tick + TW'(1);
                end
            end

            if ((r_state == ST_START) && w_advance) begin
                r_idx <= 6'd0;
            end else if ((r_state == ST_DATA) && w_advance && (r_idx != IDX_LAST)) begin
                r_idx <= r_idx + 6'd1;
            end

            // Framing bits are only checked, never stored.
            if ((r_state == ST_DATA) && w_sample && is_data_idx(r_idx)) begin
                r_shift[data_pos(r_idx)] <= w_rxd_sync;
            end

            if (w_valid_nxt) begin
                r_data <= r_shift;
            end

            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign rx_data       = r_data;
    assign rx_data_valid = r_valid;
    assign rx_frame_err  = r_err;
    assign rx_busy       = r_busy;

endmodule

// File: doc/ips2l_seu_uart_rx.md
IPS2L_SEU_UART_RX -- requirements
Module: ips2l_seu_uart_rx

Interface
REQ-001 Parameter BIT_TICKS, default 6: clk_en pulses per serial bit.
REQ-002 Parameter SAMPLE_TICK, default 2: sub-tick index, 0..BIT_TICKS-1, at which a bit is sampled.
REQ-003 clk  input  1  single clock for the whole block.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 clk_en  input  1  one-cycle baud-tick enable.
REQ-006 rxd  input  1  serial line; idles high; asynchronous to clk.
REQ-007 rx_data  output  32  last correctly received word.
REQ-008 rx_data_valid  output  1  one-cycle pulse; rx_data is new and valid.
REQ-009 rx_frame_err  output  1  one-cycle pulse; the current frame was aborted.
REQ-010 rx_busy  output  1  high while the state is not IDLE.

Function
REQ-011 The frame format SHALL be: start bit 0, then 38 bits sent LSB first, then a stop bit 1.
REQ-012 The 38 bits SHALL be, by index: 0-7 byte0, 8 = 1, 9 = 0, 10-17 byte1, 18 = 1, 19 = 0, 20-27 byte2, 28 = 1, 29 = 0, 30-37 byte3.
REQ-013 rxd SHALL pass through a two-flop synchronizer before any use; this adds 2 clk of latency.
REQ-014 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-015 In IDLE, a falling edge on the synchronized rxd (previous value 1, current value 0) SHALL clear the sub-tick counter and enter START.
REQ-016 Outside IDLE, the sub-tick counter SHALL increment on clk_en and wrap from BIT_TICKS-1 to 0.
REQ-017 Sample strobe = clk_en and (counter == SAMPLE_TICK).
REQ-018 Bit advance = clk_en and (counter == BIT_TICKS-1).
REQ-019 In START, if the sampled value is 1, the frame SHALL be treated as a glitch: return to IDLE with no output pulse.
REQ-020 In START, if the sampled value is 0, the FSM SHALL enter DATA at the next bit advance, with the bit index set to 0.
REQ-021 In DATA, every sample SHALL store into bit[index], and index SHALL increment at each bit advance.
REQ-022 After index 37 the FSM SHALL enter STOP at the next bit advance.
REQ-023 Framing check: a sample at index 8, 18 or 28 that is not 1, or at index 9, 19 or 29 that is not 0, SHALL pulse rx_frame_err on the next clk and return to IDLE immediately.
REQ-024 In STOP, a sample of 1 SHALL set rx_data = {bit[37:30], bit[27:20], bit[17:10], bit[7:0]} and pulse rx_data_valid on the next clk, then go to IDLE.
REQ-025 In STOP, a sample of 0 SHALL pulse rx_frame_err and go to IDLE, leaving rx_data unchanged.
REQ-026 rx_data SHALL hold its value between valid pulses.
REQ-027 rx_data_valid and rx_frame_err SHALL never be high in the same cycle.
REQ-028 A line held low (break) SHALL produce at most one rx_frame_err; no new frame SHALL start until rxd has been seen high again (the edge rule of REQ-015).
REQ-029 Because the FSM returns to IDLE at the stop-bit sample, a back-to-back frame (next start bit immediately after the stop bit) SHALL be received without loss.
REQ-030 When clk_en is low, no state, counter or index SHALL change, except for the synchronizer and IDLE edge detection.

Reset
REQ-031 While rst_n is low: state = IDLE, counter = 0, index = 0, rx_data = 0, rx_data_valid = 0, rx_frame_err = 0, rx_busy = 0, synchronizer flops = 1.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame with no output pulse.

Structure
REQ-033 A shared package ips2l_seu_uart_pkg SHALL hold: the state encodings (IDLE 2'b00, START 2'b01, DATA 2'b10, END/STOP 2'b11), FRAME_BITS = 38, the default BIT_TICKS, and the framing-bit index constants.
REQ-034 The synchronizer SHALL be one sub-module, ips2l_seu_sync_2ff, reset to 1.
REQ-035 The rest of the design SHALL be a single flat FSM plus datapath.

Verification
REQ-036 Send word 32'hA5C3_0F81 with clk_en every 4 clk -> exactly one rx_data_valid pulse, with rx_data = 32'hA5C30F81.
REQ-037 Send 32'h0000_0001 then 32'hFFFF_FFFE back-to-back with no idle gap -> two valid pulses, in that order, with the correct values.
REQ-038 Drive rxd low for 2 clk_en ticks, then high -> no valid pulse, no error pulse, and rx_busy returns to 0.
REQ-039 Send 32'h1234_5678 with bit 9 forced to 1 -> rx_frame_err pulses during bit 9, no valid pulse, and rx_data keeps its previous value.
REQ-040 Send 32'hDEAD_BEEF with the stop bit forced to 0 -> one rx_frame_err pulse; then hold rxd low for 100 bits -> no further pulses.
REQ-041 Assert rst_n low at bit index 20 of a frame, then send 32'hCAFE_F00D -> all outputs are 0 during reset, and the only valid pulse afterwards carries 32'hCAFEF00D.
